lsu_mem_ctrl: RTL and testbench
===============================

LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15; max cycles in WAIT before abort.
REQ-002 clk  input  1  single system clock; all state updates on posedge clk.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 ld_en  input  1  core load strobe, sampled in IDLE only.
REQ-005 st_en  input  1  core store strobe, sampled in IDLE only.
REQ-006 funct3  input  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 addr  input  32  byte address from ALU.
REQ-008 st_data  input  32  store source register value.
REQ-009 busy  output  1  high while a transaction is outstanding; core stalls.
REQ-010 done  output  1  one-cycle pulse on transaction completion.
REQ-011 ld_data  output  32  aligned, extended load result; valid when done=1 for a load.
REQ-012 err  output  1  one-cycle pulse: misaligned, illegal funct3, ld_en&st_en together, or timeout.
REQ-013 mem_request  output  1  request to memory, one-cycle pulse per transaction.
REQ-014 mem_we_re  output  1  1 = write, 0 = read.
REQ-015 mem_mask  output  4  byte-lane enables.
REQ-016 mem_address  output  8  word address = addr[9:2].
REQ-017 mem_data_in  output  32  lane-replicated store data.
REQ-018 mem_valid  input  1  memory response strobe (one cycle after mem_request).
REQ-019 mem_data_out  input  32  memory read word, valid with mem_valid.

Function
REQ-020 FSM states IDLE, REQ, WAIT; busy=1 in REQ and WAIT only.
REQ-021 IDLE: exactly one of ld_en/st_en high with legal funct3 and alignment -> latch addr, funct3, op, st_data; go REQ.
REQ-022 IDLE: illegal request (both strobes, bad funct3, H at addr[0]=1, W at addr[1:0]!=0) -> err pulse next cycle, no mem_request, stay IDLE.
REQ-023 Strobes ignored while busy=1.
REQ-024 REQ: mem_request=1 for exactly one cycle with registered mem_we_re/mask/address/data; go WAIT; counter cleared.
REQ-025 Mask: B = 0001<<addr[1:0]; H = 0011 (addr[1]=0) or 1100 (addr[1]=1); W = 1111; loads use same mask.
REQ-026 Store data: B -> {4{st_data[7:0]}}; H -> {2{st_data[15:0]}}; W -> st_data.
REQ-027 WAIT: mem_valid=1 -> done pulse next cycle, load result registered into ld_data same edge, go IDLE.
REQ-028 Load extraction: select byte/half by latched addr[1:0]; B/H sign-extend, BU/HU zero-extend, W unchanged.
REQ-029 WAIT: counter increments per cycle without mem_valid; reaching TIMEOUT -> err pulse, no done, go IDLE.
REQ-030 mem_valid outside WAIT ignored; ld_data holds last load value until next load completion.
REQ-031 Stores leave ld_data unchanged.
REQ-032 Minimum transaction: strobe cycle N, mem_request N+1, mem_valid N+2, done N+3; busy high N+1..N+2.

Reset
REQ-033 rst low forces IDLE immediately, asynchronously, including mid-transaction; no done/err generated for the aborted op.
REQ-034 Reset values: busy=0, done=0, err=0, ld_data=0, mem_request=0, mem_we_re=0, mem_mask=0, mem_address=0, mem_data_in=0, counter=0.

Structure
REQ-035 Package lsu_pkg holds state enum (IDLE/REQ/WAIT), funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW), default TIMEOUT.
REQ-036 One combinational sub-module lsu_load_align (inputs word, addr[1:0], funct3; output 32-bit result) instantiated in lsu_mem_ctrl.

Verification
REQ-037 SW addr=0x0000_0008, st_data=0xDEADBEEF -> mem_request one cycle, we_re=1, mask=1111, mem_address=0x02, mem_data_in=0xDEADBEEF, done 3 cycles after strobe.
REQ-038 LB addr=0x0000_0003, mem_data_out=0x80AA_5511 -> mask=1000, ld_data=0xFFFF_FF80; LBU same -> 0x0000_0080.
REQ-039 SH addr=0x0000_0006, st_data=0x1234_ABCD -> mask=1100, mem_data_in=0xABCD_ABCD, mem_address=0x01.
REQ-040 LW addr=0x0000_0002 -> err pulse, no mem_request, busy stays 0; ld_en=st_en=1 -> err pulse.
REQ-041 LH issued, mem_valid held 0 -> err pulse after TIMEOUT=15 wait cycles, no done, FSM back in IDLE accepting next strobe.
REQ-042 rst asserted in WAIT -> busy=0 and all outputs at reset values immediately; late mem_valid after release produces no done.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and request helpers for the load/store unit.
// Helpers assume a legal request has already been established where noted.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam int DEFAULT_TIMEOUT = 15;

  // Unsigned widths exist only for loads; halves need even, words need 4-byte alignment.
  function automatic logic req_legal(input logic ld, input logic st,
                                     input logic [2:0] f3, input logic [1:0] a);
    logic ok;
    case (f3)
      LB:      ok = 1'b1;
      LH:      ok = ~a[0];
      LW:      ok = (a == 2'b00);
      LBU:     ok = ld;
      LHU:     ok = ld & ~a[0];
      default: ok = 1'b0;
    endcase
    return ok & (ld ^ st);
  endfunction

  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] m;
    case (f3[1:0])
      2'b00:   m = 4'b0001 << a;
      2'b01:   m = a[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    case (f3[1:0])
      2'b00:   r = {4{d[7:0]}};
      2'b01:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/half out of a memory word and sign- or zero-extends it.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = addr[1] ? word[31:16] : word[15:0];
    case (funct3)
      LB:      result = {{24{byte_sel[7]}}, byte_sel};
      LBU:     result = {24'b0, byte_sel};
      LH:      result = {{16{half_sel[15]}}, half_sel};
      LHU:     result = {16'b0, half_sel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit memory controller: validates a core request, issues one memory
// transaction, and returns aligned load data or an error (illegal request or timeout).
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_en,
  input  logic        st_en,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] st_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] ld_data,
  output logic        err,
  output logic        mem_request,
  output logic        mem_we_re,
  output logic [3:0]  mem_mask,
  output logic [7:0]  mem_address,
  output logic [31:0] mem_data_in,
  input  logic        mem_valid,
  input  logic [31:0] mem_data_out
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic        mem_request_q, mem_request_d;
  logic        mem_we_re_q, mem_we_re_d;
  logic [3:0]  mem_mask_q, mem_mask_d;
  logic [7:0]  mem_address_q, mem_address_d;
  logic [31:0] mem_data_in_q, mem_data_in_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [31:0] load_word;

  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:10];

  lsu_load_align u_align (
    .word   (mem_data_out),
    .addr   (addr_lo_q),
    .funct3 (funct3_q),
    .result (load_word)
  );

  always_comb begin
    state_d       = state_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    err_d         = 1'b0;
    ld_data_d     = ld_data_q;
    mem_request_d = 1'b0;
    mem_we_re_d   = mem_we_re_q;
    mem_mask_d    = mem_mask_q;
    mem_address_d = mem_address_q;
    mem_data_in_d = mem_data_in_q;
    cnt_d         = cnt_q;
    funct3_d      = funct3_q;
    addr_lo_d     = addr_lo_q;
    case (state_q)
      IDLE: begin
        if (ld_en || st_en) begin
          if (req_legal(ld_en, st_en, funct3, addr[1:0])) begin
            // Memory-side outputs are loaded here so they are already registered in REQ.
            state_d       = REQ;
            busy_d        = 1'b1;
            mem_request_d = 1'b1;
            mem_we_re_d   = st_en;
            mem_mask_d    = lane_mask(funct3, addr[1:0]);
            mem_address_d = addr[9:2];
            mem_data_in_d = store_lanes(funct3, st_data);
            funct3_d      = funct3;
            addr_lo_d     = addr[1:0];
          end else begin
            err_d = 1'b1;
          end
        end
      end
      REQ: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        if (mem_valid) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (!mem_we_re_q) ld_data_d = load_word;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      ld_data_q     <= '0;
      mem_request_q <= 1'b0;
      mem_we_re_q   <= 1'b0;
      mem_mask_q    <= '0;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
      cnt_q         <= '0;
      funct3_q      <= '0;
      addr_lo_q     <= '0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
      ld_data_q     <= ld_data_d;
      mem_request_q <= mem_request_d;
      mem_we_re_q   <= mem_we_re_d;
      mem_mask_q    <= mem_mask_d;
      mem_address_q <= mem_address_d;
      mem_data_in_q <= mem_data_in_d;
      cnt_q         <= cnt_d;
      funct3_q      <= funct3_d;
      addr_lo_q     <= addr_lo_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign ld_data     = ld_data_q;
  assign mem_request = mem_request_q;
  assign mem_we_re   = mem_we_re_q;
  assign mem_mask    = mem_mask_q;
  assign mem_address = mem_address_q;
  assign mem_data_in = mem_data_in_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: a per-cycle expectation timeline built from transaction rules,
// checked every cycle, plus directed cases with literal expected values.
module tb_lsu_mem_ctrl;
  import lsu_pkg::*;

  localparam int TIMEOUT = 15;
  localparam int MAXC    = 8192;

  logic        clk, rst, ld_en, st_en, mem_valid;
  logic [2:0]  funct3;
  logic [31:0] addr, st_data, mem_data_out;
  logic        busy, done, err, mem_request, mem_we_re;
  logic [31:0] ld_data, mem_data_in;
  logic [3:0]  mem_mask;
  logic [7:0]  mem_address;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  bit chk_en = 0;

  bit          exp_busy[MAXC], exp_done[MAXC], exp_err[MAXC], exp_req[MAXC];
  bit          exp_we[MAXC], exp_ld_upd[MAXC];
  logic [3:0]  exp_mask[MAXC];
  logic [7:0]  exp_addr[MAXC];
  logic [31:0] exp_data[MAXC], exp_ld_val[MAXC];
  logic [31:0] model_ld = '0;

  int          req_count = 0;
  logic        cap_we = 1'b0;
  logic [3:0]  cap_mask = '0;
  logic [7:0]  cap_addr = '0;
  logic [31:0] cap_data = '0;

  lsu_mem_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .ld_en(ld_en), .st_en(st_en), .funct3(funct3),
    .addr(addr), .st_data(st_data), .busy(busy), .done(done), .ld_data(ld_data),
    .err(err), .mem_request(mem_request), .mem_we_re(mem_we_re), .mem_mask(mem_mask),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_valid(mem_valid),
    .mem_data_out(mem_data_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Reference rules: access size in bytes, legality, lanes, extraction.
  function automatic int m_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_legal(input logic ld, input logic st, input logic [2:0] f3,
                                 input logic [31:0] a);
    bit op_ok;
    if (ld == st) return 1'b0;
    case (f3)
      3'b000, 3'b001, 3'b010: op_ok = 1'b1;
      3'b100, 3'b101:         op_ok = ld;
      default:                op_ok = 1'b0;
    endcase
    if (!op_ok) return 1'b0;
    return (int'(a[1:0]) % m_size(f3)) == 0;
  endfunction

  function automatic logic [3:0] m_mask(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] m;
    m = ((32'd1 << m_size(f3)) - 32'd1) << a[1:0];
    return m[3:0];
  endfunction

  function automatic logic [31:0] m_lanes(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    int b;
    b = m_size(f3);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % b) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] word, input logic [1:0] off,
                                         input logic [2:0] f3);
    logic [31:0] v, keep;
    int b;
    b = m_size(f3);
    v = word >> (8 * int'(off));
    if (b == 4) return v;
    keep = (32'd1 << (8 * b)) - 32'd1;
    v = v & keep;
    if (!f3[2] && v[8*b-1]) v = v | ~keep;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cyc < MAXC) begin
      if (exp_ld_upd[cyc]) model_ld = exp_ld_val[cyc];
      if (mem_request === 1'b1) begin
        req_count++;
        cap_we   = mem_we_re;
        cap_mask = mem_mask;
        cap_addr = mem_address;
        cap_data = mem_data_in;
      end
      if (chk_en) begin
        checkOutput("busy", 32'(busy), 32'(exp_busy[cyc]));
        checkOutput("done", 32'(done), 32'(exp_done[cyc]));
        checkOutput("err", 32'(err), 32'(exp_err[cyc]));
        checkOutput("mem_request", 32'(mem_request), 32'(exp_req[cyc]));
        checkOutput("ld_data", ld_data, model_ld);
        if (exp_req[cyc]) begin
          checkOutput("mem_we_re", 32'(mem_we_re), 32'(exp_we[cyc]));
          checkOutput("mem_mask", 32'(mem_mask), 32'(exp_mask[cyc]));
          checkOutput("mem_address", 32'(mem_address), 32'(exp_addr[cyc]));
          if (exp_we[cyc]) checkOutput("mem_data_in", mem_data_in, exp_data[cyc]);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_quiet();
    ld_en = 1'b0;
    st_en = 1'b0;
    funct3 = 3'($urandom);
    addr = $urandom;
    st_data = $urandom;
    mem_valid = 1'($urandom);
    mem_data_out = $urandom;
  endtask

  task automatic drive_junk();
    ld_en = 1'($urandom);
    st_en = 1'($urandom);
    funct3 = 3'($urandom);
    addr = $urandom;
    st_data = $urandom;
  endtask

  // k = WAIT cycle (1..TIMEOUT) in which memory answers; 0 means it never does.
  task automatic applyStimulus(input logic ld, input logic st, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] d, input int k,
                               input logic [31:0] word);
    int n, kk;
    n = cyc;
    ld_en = ld;
    st_en = st;
    funct3 = f3;
    addr = a;
    st_data = d;
    mem_valid = 1'($urandom);
    mem_data_out = $urandom;
    if (!m_legal(ld, st, f3, a)) begin
      exp_err[n+1] = 1'b1;
      next_cycle();
      drive_quiet();
      return;
    end
    kk = (k == 0) ? TIMEOUT : k;
    exp_req[n+1]  = 1'b1;
    exp_we[n+1]   = st;
    exp_mask[n+1] = m_mask(f3, a);
    exp_addr[n+1] = a[9:2];
    exp_data[n+1] = m_lanes(f3, d);
    for (int j = 1; j <= kk + 1; j++) exp_busy[n+j] = 1'b1;
    if (k == 0) begin
      exp_err[n+2+kk] = 1'b1;
    end else begin
      exp_done[n+2+kk] = 1'b1;
      if (ld) begin
        exp_ld_upd[n+2+kk] = 1'b1;
        exp_ld_val[n+2+kk] = m_load(word, a[1:0], f3);
      end
    end
    next_cycle();
    drive_junk();
    mem_valid = 1'($urandom);
    mem_data_out = $urandom;
    for (int j = 1; j <= kk; j++) begin
      next_cycle();
      drive_junk();
      mem_valid = (j == k);
      mem_data_out = (j == k) ? word : $urandom;
    end
    next_cycle();
    drive_quiet();
  endtask

  task automatic reset_mid();
    int n;
    n = cyc;
    ld_en = 1'b1;
    st_en = 1'b0;
    funct3 = LW;
    addr = 32'h40;
    mem_valid = 1'b0;
    exp_req[n+1]  = 1'b1;
    exp_we[n+1]   = 1'b0;
    exp_mask[n+1] = 4'hF;
    exp_addr[n+1] = 8'h10;
    exp_busy[n+1] = 1'b1;
    exp_busy[n+2] = 1'b1;
    next_cycle();
    drive_quiet();
    mem_valid = 1'b0;
    next_cycle();
    #2;
    chk_en = 1'b0;
    rst = 1'b0;
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_req", 32'(mem_request), 32'd0);
    checkOutput("rst_we", 32'(mem_we_re), 32'd0);
    checkOutput("rst_mask", 32'(mem_mask), 32'd0);
    checkOutput("rst_addr", 32'(mem_address), 32'd0);
    checkOutput("rst_data_in", mem_data_in, 32'd0);
    checkOutput("rst_ld_data", ld_data, 32'd0);
    exp_ld_upd[n+3] = 1'b1;
    exp_ld_val[n+3] = '0;
    next_cycle();
    mem_valid = 1'b1;
    rst = 1'b1;
    chk_en = 1'b1;
    next_cycle();
    mem_valid = 1'b1;
    next_cycle();
    mem_valid = 1'b0;
    checkOutput("late_valid_done", 32'(done), 32'd0);
    checkOutput("late_valid_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got cycle %0d, expected < %0d", cyc, MAXC);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rc, r, k, gap;
    logic ld, st;
    logic [2:0] f3;
    logic [31:0] a;
    rst = 1'b1;
    ld_en = 1'b0;
    st_en = 1'b0;
    funct3 = '0;
    addr = '0;
    st_data = '0;
    mem_valid = 1'b0;
    mem_data_out = '0;
    #2 rst = 1'b0;
    ld_en = 1'b1;
    funct3 = LW;
    next_cycle();
    next_cycle();
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_err", 32'(err), 32'd0);
    checkOutput("reset_req", 32'(mem_request), 32'd0);
    checkOutput("reset_mask", 32'(mem_mask), 32'd0);
    checkOutput("reset_ld_data", ld_data, 32'd0);
    drive_quiet();
    rst = 1'b1;
    chk_en = 1'b1;
    next_cycle();

    applyStimulus(1'b0, 1'b1, SW, 32'h0000_0008, 32'hDEADBEEF, 1, 32'h0);
    checkOutput("sw_done_n3", 32'(done), 32'd1);
    checkOutput("sw_we", 32'(cap_we), 32'd1);
    checkOutput("sw_mask", 32'(cap_mask), 32'hF);
    checkOutput("sw_addr", 32'(cap_addr), 32'h02);
    checkOutput("sw_data", cap_data, 32'hDEADBEEF);

    applyStimulus(1'b1, 1'b0, LB, 32'h0000_0003, 32'h0, 2, 32'h80AA_5511);
    checkOutput("lb_mask", 32'(cap_mask), 32'h8);
    checkOutput("lb_ld_data", ld_data, 32'hFFFF_FF80);
    applyStimulus(1'b1, 1'b0, LBU, 32'h0000_0003, 32'h0, 1, 32'h80AA_5511);
    checkOutput("lbu_ld_data", ld_data, 32'h0000_0080);

    applyStimulus(1'b0, 1'b1, SH, 32'h0000_0006, 32'h1234_ABCD, 3, 32'h0);
    checkOutput("sh_mask", 32'(cap_mask), 32'hC);
    checkOutput("sh_data", cap_data, 32'hABCD_ABCD);
    checkOutput("sh_addr", 32'(cap_addr), 32'h01);
    checkOutput("sh_ld_hold", ld_data, 32'h0000_0080);

    rc = req_count;
    applyStimulus(1'b1, 1'b0, LW, 32'h0000_0002, 32'h0, 1, 32'h0);
    checkOutput("lw_mis_err", 32'(err), 32'd1);
    checkOutput("lw_mis_busy", 32'(busy), 32'd0);
    next_cycle();
    checkOutput("lw_mis_noreq", 32'(req_count), 32'(rc));
    applyStimulus(1'b1, 1'b1, LW, 32'h0000_0000, 32'h0, 1, 32'h0);
    checkOutput("both_err", 32'(err), 32'd1);
    next_cycle();

    applyStimulus(1'b1, 1'b0, LH, 32'h0000_0004, 32'h0, 0, 32'h0);
    checkOutput("tmo_err", 32'(err), 32'd1);
    checkOutput("tmo_done", 32'(done), 32'd0);
    checkOutput("tmo_ld_hold", ld_data, 32'h0000_0080);
    applyStimulus(1'b1, 1'b0, LW, 32'h0000_0100, 32'h0, 1, 32'h0123_4567);
    checkOutput("after_tmo_ld", ld_data, 32'h0123_4567);

    reset_mid();

    for (int t = 0; t < 300 && cyc < MAXC - 64; t++) begin
      r = $urandom_range(0, 19);
      ld = (r < 9) || (r >= 18);
      st = (r >= 9);
      if ($urandom_range(0, 4) == 0) f3 = 3'($urandom);
      else if (ld && !st) f3 = (r % 5 == 3) ? LBU : (r % 5 == 4) ? LHU : 3'($urandom_range(0, 2));
      else f3 = 3'($urandom_range(0, 2));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'b01) a[0] = 1'b0;
        if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
      end
      r = $urandom_range(0, 9);
      k = (r == 0) ? 0 : (r < 7) ? $urandom_range(1, 3) : $urandom_range(1, TIMEOUT);
      applyStimulus(ld, st, f3, a, $urandom, k, $urandom);
      gap = $urandom_range(0, 2);
      repeat (gap) next_cycle();
    end

    repeat (3) next_cycle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
